// File: rtl/bus_perf_monitor.sv
// bus_perf_monitor: passive observer of the CPU<->cache bus (C1/A1) and the
// cache<->memory-controller bus (C2/A2). It delimits CPU transactions,
// classifies each as hit or miss from line fetches on bus 2, counts
// write-backs, measures latency and raises sticky protocol flags.
// Optional build macro MON_TRACE_EN: print one line per completed transaction
// and one line the first time each error flag is set.
//
//   state | meaning
//   IDLE  | no transaction open; any non-zero C1 is a new command
//   REQ   | CPU still driving the command (multi-beat writes repeat it)
//   BUSY  | command done, waiting for the cache response
//   RESP  | response beats (C1 == 7) in progress
module bus_perf_monitor #(
  parameter int CNT_W   = 32,
  parameter int LAT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [2:0]       C1,
  input  logic [14:0]      A1,
  input  logic [1:0]       C2,
  input  logic [14:0]      A2,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt,
  output logic [CNT_W-1:0] lat_sum,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic [14:0]      last_addr,
  output logic             busy,
  output logic [2:0]       err
);

  localparam logic [2:0]       C1_NOP     = 3'd0;
  localparam logic [2:0]       C1_RESP    = 3'd7;
  localparam logic [1:0]       C2_READ    = 2'd2;
  localparam logic [1:0]       C2_WRITE   = 2'd3;
  localparam logic [LAT_W-1:0] TMO_LIMIT  = LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] LAT_ONES   = '1;
  localparam logic [CNT_W-1:0] CNT_ONES   = '1;

  typedef enum logic [1:0] {IDLE, REQ, BUSY, RESP} state_t;

  state_t           state, state_d;
  logic [2:0]       cmd;
  logic             miss;
  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] lat_inc;
  logic [1:0]       c2_prev;
  logic             start, done, tmo;
  logic             rd_rise, wb_rise, is_miss, idle_c2;
  logic             err_tmo, err_c2;
  logic [CNT_W:0]   sum_ext;

  // The memory-bus address carries nothing needed for classification.
  logic unused_a2;
  assign unused_a2 = ^A2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_ONES) ? v : v + CNT_W'(1);
  endfunction

  assign lat_inc = (lat == LAT_ONES) ? lat : lat + LAT_W'(1);
  assign rd_rise = (C2 == C2_READ)  && (c2_prev != C2_READ);
  assign wb_rise = (C2 == C2_WRITE) && (c2_prev != C2_WRITE);
  assign is_miss = miss || (C2 == C2_READ);
  assign idle_c2 = (state == IDLE) && C2[1];
  assign sum_ext = {1'b0, lat_sum} + (CNT_W+1)'(lat_inc);
  assign busy    = (state != IDLE);
  // Every C1 value seen in IDLE is a command, so no stray response can be
  // observed there and bit 0 stays clear.
  assign err     = {err_c2, err_tmo, 1'b0};

  // Next-state decode plus transaction start/completion/timeout strobes.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE: begin
        if (C1 != C1_NOP) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (C1 == cmd) begin
          state_d = REQ;
        end else if (C1 == C1_RESP) begin
          // A non-matching value ends the command phase and is already the
          // first BUSY sample, so a response here completes immediately.
          done    = 1'b1;
          state_d = RESP;
        end else begin
          state_d = BUSY;
        end
        if (!done && (lat_inc >= TMO_LIMIT)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (C1 == C1_RESP) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (lat_inc >= TMO_LIMIT) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (C1 != C1_RESP) begin
          if (C1 != C1_NOP) begin
            start   = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and per-transaction context (command, address, latency, miss).
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cmd       <= 3'd0;
      last_addr <= 15'd0;
      lat       <= '0;
      miss      <= 1'b0;
      c2_prev   <= 2'd0;
    end else begin
      state   <= state_d;
      c2_prev <= C2;
      if (start) begin
        cmd       <= C1;
        last_addr <= A1;
        lat       <= '0;
        miss      <= (state != IDLE) && rd_rise;
      end else begin
        if ((state == REQ) || (state == BUSY))
          lat <= lat_inc;
        if ((state != IDLE) && rd_rise)
          miss <= 1'b1;
      end
    end
  end

  // Event and latency statistics, all saturating.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      req_cnt  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
      lat_sum  <= '0;
      last_lat <= '0;
      max_lat  <= '0;
    end else begin
      if (wb_rise)
        wb_cnt <= sat_inc(wb_cnt);
      if (done) begin
        req_cnt  <= sat_inc(req_cnt);
        if (is_miss)
          miss_cnt <= sat_inc(miss_cnt);
        else
          hit_cnt  <= sat_inc(hit_cnt);
        last_lat <= lat_inc;
        lat_sum  <= sum_ext[CNT_W] ? CNT_ONES : sum_ext[CNT_W-1:0];
        if (lat_inc > max_lat)
          max_lat <= lat_inc;
      end
    end
  end

  // Sticky protocol flags: timeout and bus-2 command while bus 1 is idle.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      err_tmo <= 1'b0;
      err_c2  <= 1'b0;
    end else begin
      if (tmo)
        err_tmo <= 1'b1;
      if (idle_c2)
        err_c2 <= 1'b1;
    end
  end

`ifdef MON_TRACE_EN
  // Trace completed transactions and the first occurrence of each flag.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      if (done)
        $display("[bus_perf_monitor] t=%0t cmd=%0d addr=0x%04h %s lat=%0d",
                 $time, cmd, last_addr, is_miss ? "MISS" : "HIT", lat_inc);
      if (tmo && !err_tmo)
        $display("[bus_perf_monitor] t=%0t err[1] set: response timeout", $time);
      if (idle_c2 && !err_c2)
        $display("[bus_perf_monitor] t=%0t err[2] set: bus-2 command while idle", $time);
    end
  end
`else
  // Trace disabled: the monitor is silent; counters and flags are unaffected.
`endif

endmodule

// File: tb/tb_bus_perf_monitor.sv
// Directed bench for bus_perf_monitor: hand-computed counter, latency and
// flag values for miss, hit, write-back, timeout, idle bus-2, reset and
// back-to-back scenarios.
module tb_bus_perf_monitor;

  logic        clk;
  logic        RESET;
  logic [2:0]  C1;
  logic [14:0] A1;
  logic [1:0]  C2;
  logic [14:0] A2;
  logic [31:0] req_cnt, hit_cnt, miss_cnt, wb_cnt, lat_sum;
  logic [15:0] last_lat, max_lat;
  logic [14:0] last_addr;
  logic        busy;
  logic [2:0]  err;

  int n_tests = 0;
  int n_fail  = 0;

  bus_perf_monitor dut (
    .clk       (clk),
    .RESET     (RESET),
    .C1        (C1),
    .A1        (A1),
    .C2        (C2),
    .A2        (A2),
    .req_cnt   (req_cnt),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt),
    .lat_sum   (lat_sum),
    .last_lat  (last_lat),
    .max_lat   (max_lat),
    .last_addr (last_addr),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive both buses, let one rising edge sample them, settle 1 ns after.
  task automatic step(input logic [2:0] c1v, input logic [14:0] a1v, input logic [1:0] c2v);
    C1 = c1v;
    A1 = a1v;
    C2 = c2v;
    A2 = a1v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    C1 = 3'd0; A1 = 15'd0; C2 = 2'd0; A2 = 15'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_cnt", req_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_max_lat", max_lat, 0);
    RESET = 1'b0;
    step(3'd0, 15'h0, 2'd0);

    // Cold READ8 @0x0010, line fetch on bus 2, response 18 edges later.
    step(3'd1, 15'h0010, 2'd0);
    check("t1_busy_after_cmd", busy, 1);
    check("t1_addr", last_addr, 15'h0010);
    for (int i = 1; i <= 17; i++)
      step(3'd0, 15'h0010, (i == 2 || i == 3) ? 2'd2 : ((i == 5) ? 2'd1 : 2'd0));
    check("t1_no_early_done", req_cnt, 0);
    step(3'd7, 15'h0010, 2'd0);
    check("t1_req_cnt", req_cnt, 1);
    check("t1_miss_cnt", miss_cnt, 1);
    check("t1_hit_cnt", hit_cnt, 0);
    check("t1_last_lat", last_lat, 18);
    check("t1_lat_sum", lat_sum, 18);
    step(3'd0, 15'h0010, 2'd0);
    check("t1_busy_fall", busy, 0);

    // Repeat READ8, hit, response at +6.
    step(3'd1, 15'h0010, 2'd0);
    for (int i = 1; i <= 5; i++) step(3'd0, 15'h0010, 2'd0);
    step(3'd7, 15'h0010, 2'd0);
    check("t2_hit_cnt", hit_cnt, 1);
    check("t2_miss_cnt", miss_cnt, 1);
    check("t2_last_lat", last_lat, 6);
    check("t2_max_lat", max_lat, 18);
    check("t2_lat_sum", lat_sum, 24);
    step(3'd0, 15'h0010, 2'd0);

    // WRITE32 held 2 edges, eviction write-back then line fetch.
    step(3'd7, 15'h0200, 2'd0);
    step(3'd7, 15'h0200, 2'd0);
    check("t3_no_false_done", req_cnt, 2);
    check("t3_busy", busy, 1);
    for (int i = 2; i <= 11; i++)
      step(3'd0, 15'h0200, (i == 3 || i == 4) ? 2'd3 : ((i == 6 || i == 7) ? 2'd2 : 2'd0));
    step(3'd7, 15'h0200, 2'd0);
    check("t3_wb_cnt", wb_cnt, 1);
    check("t3_miss_cnt", miss_cnt, 2);
    check("t3_req_cnt", req_cnt, 3);
    check("t3_last_lat", last_lat, 12);
    check("t3_lat_sum", lat_sum, 36);
    step(3'd0, 15'h0200, 2'd0);

    // No response: timeout at edge 255.
    step(3'd1, 15'h0300, 2'd0);
    for (int i = 1; i <= 254; i++) step(3'd0, 15'h0300, 2'd0);
    check("t4_busy_before_tmo", busy, 1);
    check("t4_err_before_tmo", err, 3'b000);
    step(3'd0, 15'h0300, 2'd0);
    check("t4_err_tmo", err, 3'b010);
    check("t4_busy_after_tmo", busy, 0);
    check("t4_req_unchanged", req_cnt, 3);
    check("t4_last_lat_unchanged", last_lat, 12);

    // Line fetch while bus 1 is idle.
    step(3'd0, 15'h0000, 2'd2);
    check("t5_err_c2", err, 3'b110);
    check("t5_miss_unchanged", miss_cnt, 2);
    check("t5_req_unchanged", req_cnt, 3);
    step(3'd0, 15'h0000, 2'd0);

    // Reset asserted mid-BUSY clears everything at once.
    step(3'd2, 15'h0400, 2'd0);
    step(3'd0, 15'h0400, 2'd0);
    step(3'd0, 15'h0400, 2'd0);
    check("t6_busy_pre_rst", busy, 1);
    RESET = 1'b1;
    #1;
    check("t6_rst_req_cnt", req_cnt, 0);
    check("t6_rst_wb_cnt", wb_cnt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_addr", last_addr, 0);
    check("t6_rst_max_lat", max_lat, 0);
    @(posedge clk);
    #1;
    RESET = 1'b0;
    step(3'd0, 15'h0000, 2'd0);

    // Back-to-back: READ16 issued on the RESP-exit edge.
    step(3'd1, 15'h0010, 2'd0);
    for (int i = 1; i <= 3; i++) step(3'd0, 15'h0010, 2'd0);
    step(3'd7, 15'h0010, 2'd0);
    check("t7_first_req", req_cnt, 1);
    check("t7_first_lat", last_lat, 4);
    step(3'd2, 15'h0020, 2'd0);
    check("t7_b2b_busy", busy, 1);
    check("t7_b2b_addr", last_addr, 15'h0020);
    for (int i = 1; i <= 4; i++) step(3'd0, 15'h0020, 2'd0);
    step(3'd7, 15'h0020, 2'd0);
    check("t7_req_cnt", req_cnt, 2);
    check("t7_hit_cnt", hit_cnt, 2);
    check("t7_last_lat", last_lat, 5);
    check("t7_lat_sum", lat_sum, 9);
    check("t7_max_lat", max_lat, 5);
    step(3'd0, 15'h0020, 2'd0);
    check("t7_busy_fall", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
